mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch requester (I) and the load/store requester (D) of the CPU.
- Enforces one outstanding memory transaction at a time.
- Gives D priority by default, with a starvation guard for I and a response timeout.
- Sits between the CPU's PC/fetch logic and load/store unit on one side and the memory on the other.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (I) and load/store (D).
// One transaction in flight; D wins by default, I is forced through after MAX_WAIT D grants.
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int MAX_WAIT     = 4,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [WIDTH-1:0]   i_addr,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [WIDTH-1:0]   i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [WIDTH/8-1:0] d_be,
  input  logic [WIDTH-1:0]   d_addr,
  input  logic [WIDTH-1:0]   d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [WIDTH-1:0]   d_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH/8-1:0] mem_be,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               owner,
  output logic               err
);

  localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int TW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, RSP_I, RSP_D} state_t;

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [TW-1:0] tmo_reg, tmo_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      starve_reg <= '0;
      tmo_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      starve_reg <= starve_next;
      tmo_reg    <= tmo_next;
    end
  end

  assign owner = owner_reg;

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    starve_next = starve_reg;
    tmo_next    = tmo_reg;
    i_gnt       = 1'b0;
    i_rvalid    = 1'b0;
    i_rdata     = '0;
    d_gnt       = 1'b0;
    d_rvalid    = 1'b0;
    d_rdata     = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    err         = 1'b0;

    case (state_reg)
      IDLE: begin
        // I is forced through once D has won MAX_WAIT times in a row while I waited
        if (d_req && !(i_req && starve_reg == STARVE_MAX)) begin
          state_next = REQ_D;
          owner_next = 1'b1;
        end else if (i_req) begin
          state_next = REQ_I;
          owner_next = 1'b0;
        end
      end

      REQ_I: begin
        tmo_next = '0;
        mem_req  = i_req;
        mem_be   = '1;
        mem_addr = i_addr;
        i_gnt    = mem_gnt & i_req;
        if (!i_req)       state_next = IDLE;
        else if (mem_gnt) state_next = RSP_I;
      end

      REQ_D: begin
        tmo_next  = '0;
        mem_req   = d_req;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_gnt     = mem_gnt & d_req;
        if (!d_req)       state_next = IDLE;
        else if (mem_gnt) state_next = RSP_D;
      end

      RSP_I: begin
        if (mem_rvalid) begin
          i_rvalid   = 1'b1;
          i_rdata    = mem_rdata;
          state_next = IDLE;
        end else if (tmo_reg == TMO_LAST) begin
          i_rvalid   = 1'b1;
          err        = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      RSP_D: begin
        if (mem_rvalid) begin
          d_rvalid   = 1'b1;
          d_rdata    = mem_rdata;
          state_next = IDLE;
        end else if (tmo_reg == TMO_LAST) begin
          d_rvalid   = 1'b1;
          err        = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      default: state_next = IDLE;
    endcase

    // Count D grants that I had to watch; any I grant or idle I clears the count
    if (!i_req || i_gnt)
      starve_next = '0;
    else if (d_gnt && starve_reg != STARVE_MAX)
      starve_next = starve_reg + SW'(1);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a phase-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_port_arbiter;

  localparam int WIDTH        = 32;
  localparam int MAX_WAIT     = 4;
  localparam int RESP_TIMEOUT = 16;

  logic        clk, rst;
  logic        i_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, owner, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: which side holds the memory (0 none, 1 I, 2 D), whether it has been
  // granted, how long the response has been outstanding, and I's wait count.
  int m_side, m_age, m_starve;
  bit m_granted, m_own;

  typedef struct packed {
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        err;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    bit   done;
    e = '0;
    if (m_side != 0 && !m_granted) begin
      if (m_side == 1) begin
        e.mem_req  = i_req;
        e.mem_be   = 4'hf;
        e.mem_addr = i_addr;
        e.i_gnt    = i_req & mem_gnt;
      end else begin
        e.mem_req   = d_req;
        e.mem_we    = d_we;
        e.mem_be    = d_be;
        e.mem_addr  = d_addr;
        e.mem_wdata = d_wdata;
        e.d_gnt     = d_req & mem_gnt;
      end
    end else if (m_granted) begin
      done  = mem_rvalid || (m_age == RESP_TIMEOUT - 1);
      e.err = !mem_rvalid && (m_age == RESP_TIMEOUT - 1);
      if (m_side == 1) begin
        e.i_rvalid = done;
        e.i_rdata  = mem_rvalid ? mem_rdata : 32'h0;
      end else begin
        e.d_rvalid = done;
        e.d_rdata  = mem_rvalid ? mem_rdata : 32'h0;
      end
    end
    return e;
  endfunction

  exp_t cur;
  always_comb cur = model_out();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_side    <= 0;
      m_granted <= 1'b0;
      m_age     <= 0;
      m_starve  <= 0;
      m_own     <= 1'b0;
    end else begin
      if (!i_req || cur.i_gnt)
        m_starve <= 0;
      else if (cur.d_gnt)
        m_starve <= (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
      if (m_side == 0) begin
        if (d_req && !(i_req && m_starve == MAX_WAIT)) begin
          m_side <= 2;
          m_own  <= 1'b1;
        end else if (i_req) begin
          m_side <= 1;
          m_own  <= 1'b0;
        end
      end else if (!m_granted) begin
        if (!((m_side == 1) ? i_req : d_req))
          m_side <= 0;
        else if (mem_gnt) begin
          m_granted <= 1'b1;
          m_age     <= 0;
        end
      end else begin
        if (cur.i_rvalid || cur.d_rvalid) begin
          m_side    <= 0;
          m_granted <= 1'b0;
        end else
          m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_req", mem_req, cur.mem_req);
      chk("i_gnt", i_gnt, cur.i_gnt);
      chk("d_gnt", d_gnt, cur.d_gnt);
      chk("i_rvalid", i_rvalid, cur.i_rvalid);
      chk("d_rvalid", d_rvalid, cur.d_rvalid);
      chk("err", err, cur.err);
      chk("owner", owner, m_own);
      chk("gnt_excl", i_gnt & d_gnt, 0);
      chk("rvalid_excl", i_rvalid & d_rvalid, 0);
      if (cur.i_rvalid) chk("i_rdata", i_rdata, cur.i_rdata);
      if (cur.d_rvalid && cur.err) chk("d_rdata", d_rdata, cur.d_rdata);
      if (cur.d_rvalid && !cur.err && !d_we) chk("d_rdata", d_rdata, cur.d_rdata);
      if (cur.mem_req) begin
        chk("mem_addr", mem_addr, cur.mem_addr);
        chk("mem_we", mem_we, cur.mem_we);
        chk("mem_be", mem_be, cur.mem_be);
        if (cur.mem_we) chk("mem_wdata", mem_wdata, cur.mem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear();
    tick();
    tick();
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_owner", owner, 0);
    chk("rst_flags", {i_gnt, d_gnt, i_rvalid, d_rvalid, err}, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // single fetch, 1-cycle arbitration latency
    i_req = 1; i_addr = 32'h10; mem_gnt = 1;
    #2 chk("t1_latency", mem_req, 0);
    tick();
    #2;
    chk("t1_mem_req", mem_req, 1);
    chk("t1_i_gnt", i_gnt, 1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_be", mem_be, 4'hf);
    tick();
    i_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    #2;
    chk("t1_i_rvalid", i_rvalid, 1);
    chk("t1_i_rdata", i_rdata, 32'h00500093);
    chk("t1_owner", owner, 0);
    tick();
    clear();
    tick();

    // simultaneous requests: D first, then I
    i_req = 1; i_addr = 32'h20; d_req = 1; d_addr = 32'h40; mem_gnt = 1;
    tick();
    #2;
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_i_gnt", i_gnt, 0);
    chk("t2_owner", owner, 1);
    tick();
    d_req = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #2;
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_d_rdata", d_rdata, 32'hDEADBEEF);
    tick();
    mem_rvalid = 0;
    tick();
    #2;
    chk("t2_i_gnt_next", i_gnt, 1);
    chk("t2_i_addr", mem_addr, 32'h20);
    tick();
    i_req = 0; mem_rvalid = 1; mem_rdata = 32'h13;
    tick();
    clear();
    tick();

    // starvation guard: four D grants, then I, then D again once the count cleared
    for (int k = 0; k < 6; k++) begin
      i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h100 + 32'(k * 4);
      mem_gnt = 1; mem_rvalid = 0;
      tick();
      #2;
      chk("t3_d_gnt", d_gnt, (k != 4) ? 1 : 0);
      chk("t3_i_gnt", i_gnt, (k == 4) ? 1 : 0);
      tick();
      if (k == 4) i_req = 0;
      mem_rvalid = 1; mem_rdata = 32'(k);
      tick();
    end
    clear();
    tick();

    // store with memory grant held off 3 cycles
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h80; d_wdata = 32'h1234ABCD;
    tick();
    for (int j = 0; j < 3; j++) begin
      #2;
      chk("t4_mem_req", mem_req, 1);
      chk("t4_payload", mem_wdata, 32'h1234ABCD);
      chk("t4_be_we", {mem_be, mem_we}, 5'b00111);
      chk("t4_no_gnt", d_gnt, 0);
      tick();
    end
    mem_gnt = 1;
    #2 chk("t4_d_gnt", d_gnt, 1);
    tick();
    d_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    #2 chk("t4_ack", d_rvalid, 1);
    tick();
    clear();
    tick();

    // timeout, with an illegal rvalid in the grant cycle ignored
    d_req = 1; d_addr = 32'h44; mem_gnt = 1;
    tick();
    mem_rvalid = 1; mem_rdata = 32'h1111;
    #2;
    chk("t5_d_gnt", d_gnt, 1);
    chk("t5_gnt_rvalid", d_rvalid, 0);
    tick();
    d_req = 0; mem_gnt = 0; mem_rvalid = 0;
    for (int j = 1; j <= 16; j++) begin
      #2;
      chk("t5_err", err, (j == 16) ? 1 : 0);
      chk("t5_d_rvalid", d_rvalid, (j == 16) ? 1 : 0);
      if (j == 16) chk("t5_d_rdata", d_rdata, 0);
      tick();
    end
    mem_rvalid = 1; mem_rdata = 32'h5555;
    #2;
    chk("t5_late_rvalid", {d_rvalid, i_rvalid, err, mem_req}, 0);
    tick();
    clear();
    tick();

    // rvalid in the timeout cycle wins over the timeout
    d_req = 1; d_addr = 32'h48; mem_gnt = 1;
    tick();
    tick();
    d_req = 0; mem_gnt = 0;
    for (int j = 1; j <= 16; j++) begin
      if (j == 16) begin
        mem_rvalid = 1; mem_rdata = 32'h77;
      end
      #2;
      if (j == 16) begin
        chk("t5b_d_rvalid", d_rvalid, 1);
        chk("t5b_d_rdata", d_rdata, 32'h77);
        chk("t5b_err", err, 0);
      end
      tick();
    end
    clear();
    tick();

    // asynchronous reset while in the fetch response state
    i_req = 1; i_addr = 32'h30; mem_gnt = 1;
    tick();
    tick();
    i_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h99;
    #2 chk("t6_pre_rvalid", i_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_rvalid", i_rvalid, 0);
    chk("t6_rst_rdata", i_rdata, 0);
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_owner", owner, 0);
    tick();
    mem_rvalid = 0;
    tick();
    rst = 1'b0;
    tick();
    i_req = 1; i_addr = 32'h34; mem_gnt = 1;
    tick();
    #2;
    chk("t6_i_gnt", i_gnt, 1);
    chk("t6_mem_addr", mem_addr, 32'h34);
    tick();
    i_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    #2;
    chk("t6_i_rvalid", i_rvalid, 1);
    chk("t6_i_rdata", i_rdata, 32'h0BADF00D);
    tick();
    clear();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
